// File: rtl/pwm_pkg.sv
// Shared constants and types for the 16-output PWM peripheral.
// Optional build macro PWM_DUTY_SHADOW_EN is consumed by pwm_peripheral.
package pwm_pkg;

  localparam int unsigned DIV_DEFAULT = 12;
  localparam int unsigned PWM_CNT_W   = 8;
  localparam int unsigned NUM_OUT     = 16;
  localparam int unsigned EN_BYTE_W   = 8;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;

  // Prescaler width able to hold 0..div; never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div == 0) ? 1 : 32'($clog2(div + 1));
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Register-file side of the PWM peripheral: enable bytes and shared duty value.
interface pwm_if;
  import pwm_pkg::*;

  logic [EN_BYTE_W-1:0] en_reg_out_7_0;
  logic [EN_BYTE_W-1:0] en_reg_out_15_8;
  logic [EN_BYTE_W-1:0] en_reg_pwm_7_0;
  logic [EN_BYTE_W-1:0] en_reg_pwm_15_8;
  pwm_cnt_t             pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the last clk of every PWM period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  output pwm_cnt_t pwm_cnt,
  output logic     period_start
);

  localparam int unsigned        PRE_W    = presc_width(DIV);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV);
  localparam pwm_cnt_t           CNT_LAST = '1;

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  pwm_cnt_t         cnt_d;
  logic             tick_c;

  always_comb begin
    tick_c = (pre_q == PRE_LAST);
    pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    cnt_d  = tick_c ? pwm_cnt + PWM_CNT_W'(1) : pwm_cnt;
  end

  // period_start is registered from next-state values so it coincides with tick at cnt 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q        <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      pwm_cnt      <= cnt_d;
      period_start <= (pre_d == PRE_LAST) && (cnt_d == CNT_LAST);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output static/PWM driver sharing one duty value and one period counter.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_if.slave               regs,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  pwm_cnt_t           pwm_cnt;
  pwm_cnt_t           duty_eff;
  logic [NUM_OUT-1:0] en_out_c;
  logic [NUM_OUT-1:0] en_pwm_c;
  logic [NUM_OUT-1:0] out_d;
  logic               pwm_sig_c;

  pwm_timebase #(.DIV(DIV)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  pwm_cnt_t duty_shadow;

  // Loaded on the last clk of a period so the new duty starts cleanly at cnt 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (period_start) begin
      duty_shadow <= regs.pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = regs.pwm_duty_cycle;
`endif

  // 0xFF is forced fully on; otherwise high while the counter is below duty.
  always_comb begin
    en_out_c  = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
    en_pwm_c  = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
    pwm_sig_c = (duty_eff == DUTY_FULL) || (pwm_cnt < duty_eff);
    out_d     = en_out_c & (~en_pwm_c | {NUM_OUT{pwm_sig_c}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: stimulus queues expectations, a negedge monitor checks them.
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int unsigned DIV      = 12;
  localparam int unsigned TICK     = DIV + 1;
  localparam int unsigned PERIOD   = 256 * TICK;
  localparam int unsigned PS_BOUND = PERIOD + 16;

  typedef enum int {K_OUT, K_PS, K_HI, K_GAP, K_TOG, K_CLR, K_VAL, K_TIMEOUT} kind_e;

  typedef struct {
    kind_e       kind;
    string       name;
    int unsigned act;
    int unsigned exp;
  } item_t;

  logic               clk;
  logic               rst_n;
  logic [NUM_OUT-1:0] out;
  logic               period_start;

  pwm_if regs ();

  pwm_peripheral #(.DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .regs         (regs),
    .out          (out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t sb[$];

  int unsigned tests;
  int unsigned fails;
  int unsigned cyc;
  int unsigned toggles;
  int unsigned hi_acc;
  int unsigned hi_last;
  int unsigned gap_last;
  int unsigned last_ps;
  logic [NUM_OUT-1:0] prev_out;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: update per-cycle measurements, then retire every queued expectation.
  initial begin
    item_t it;
    tests = 0; fails = 0; cyc = 0; toggles = 0;
    hi_acc = 0; hi_last = 0; gap_last = 0; last_ps = 0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out != prev_out) toggles++;
      prev_out = out;
      if (period_start === 1'b1) begin
        hi_last  = hi_acc;
        gap_last = cyc - last_ps;
        last_ps  = cyc;
        hi_acc   = 0;
      end
      if (out[0] === 1'b1) hi_acc++;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_OUT:   check(it.name, 32'(out), it.exp);
          K_PS:    check(it.name, 32'(period_start), it.exp);
          K_HI:    check(it.name, hi_last, it.exp);
          K_GAP:   check(it.name, gap_last, it.exp);
          K_TOG:   check(it.name, toggles, it.exp);
          K_VAL:   check(it.name, it.act, it.exp);
          K_CLR:   toggles = 0;
          default: begin
            tests++;
            fails++;
            $display("FAIL %s: period_start not seen within %0d clk", it.name, PS_BOUND);
          end
        endcase
      end
    end
  end

  task automatic expect_item(input kind_e k, input string n, input int unsigned e);
    item_t it;
    it.kind = k;
    it.name = n;
    it.act  = 0;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic expect_val(input string n, input int unsigned a, input int unsigned e);
    item_t it;
    it.kind = K_VAL;
    it.name = n;
    it.act  = a;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the caller inside the period_start cycle; the next clk has pwm_cnt 0.
  task automatic wait_ps(input string n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < PS_BOUND && !seen; i++) begin
      step(1);
      seen = period_start;
    end
    if (!seen) expect_item(K_TIMEOUT, n, 0);
  endtask

  initial begin
    #(64'd10 * 64'd95000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit          seen;

    regs.en_reg_out_7_0  = 8'h00;
    regs.en_reg_out_15_8 = 8'h00;
    regs.en_reg_pwm_7_0  = 8'h00;
    regs.en_reg_pwm_15_8 = 8'h00;
    regs.pwm_duty_cycle  = 8'h00;
    rst_n = 1'b0;

    // Reset and idle
    step(2);
    expect_item(K_OUT, "reset_out", 0);
    expect_item(K_PS,  "reset_ps", 0);
    rst_n = 1'b1;
    expect_item(K_CLR, "clr", 0);
    step(PERIOD);
    expect_item(K_TOG, "idle_toggles", 0);
    expect_item(K_OUT, "idle_out", 0);

    // Static enables, one clk latency
    regs.en_reg_out_7_0 = 8'h01;
    expect_item(K_OUT, "static_before_edge", 0);
    step(1);
    expect_item(K_OUT, "static_lo", 16'h0001);
    regs.en_reg_out_15_8 = 8'h80;
    step(1);
    expect_item(K_OUT, "static_hi", 16'h8001);
    regs.en_reg_pwm_15_8 = 8'h80;
    step(1);
    expect_item(K_OUT, "pwm_duty0_bit15", 16'h0001);

    // 50 % PWM on two phase-aligned outputs
    regs.en_reg_out_7_0  = 8'h01;
    regs.en_reg_out_15_8 = 8'h01;
    regs.en_reg_pwm_7_0  = 8'h01;
    regs.en_reg_pwm_15_8 = 8'h01;
    regs.pwm_duty_cycle  = 8'h80;
    wait_ps("pwm_sync0");
    wait_ps("pwm_sync1");
    expect_item(K_HI,  "pwm80_high", 1664);
    expect_item(K_GAP, "pwm80_period", PERIOD);
    step(1 + 16'h10 * TICK);
    expect_item(K_OUT, "aligned_high", 16'h0101);
    step(16'h80 * TICK);
    expect_item(K_OUT, "aligned_low", 16'h0000);

    // Duty extremes
    regs.pwm_duty_cycle = 8'h00;
    wait_ps("d00_sync0");
    wait_ps("d00_sync1");
    expect_item(K_CLR, "clr", 0);
    wait_ps("d00_run0");
    wait_ps("d00_run1");
    expect_item(K_TOG, "duty00_toggles", 0);
    expect_item(K_OUT, "duty00_out", 16'h0000);
    expect_item(K_HI,  "duty00_high", 0);

    regs.pwm_duty_cycle = 8'hFF;
    wait_ps("dff_sync0");
    wait_ps("dff_sync1");
    expect_item(K_CLR, "clr", 0);
    wait_ps("dff_run0");
    wait_ps("dff_run1");
    expect_item(K_TOG, "dutyff_toggles", 0);
    expect_item(K_OUT, "dutyff_out", 16'h0101);
    expect_item(K_HI,  "dutyff_high", PERIOD);

    // Duty change mid-period: 0x40 -> 0xC0 at pwm_cnt 0x10
    regs.pwm_duty_cycle = 8'h40;
    wait_ps("shadow_sync0");
    wait_ps("shadow_sync1");
    step(1 + 16'h10 * TICK);
    regs.pwm_duty_cycle = 8'hC0;
    step(16'h40 * TICK);
`ifdef PWM_DUTY_SHADOW_EN
    expect_item(K_OUT, "duty_change_mid", 16'h0000);
    wait_ps("shadow_end0");
    expect_item(K_HI, "duty_change_cur_high", 832);
`else
    expect_item(K_OUT, "duty_change_mid", 16'h0101);
    wait_ps("shadow_end0");
    expect_item(K_HI, "duty_change_cur_high", 2496);
`endif
    wait_ps("shadow_end1");
    expect_item(K_HI,  "duty_change_next_high", 2496);
    expect_item(K_GAP, "duty_change_period", PERIOD);

    // Reset at pwm_cnt 0x50, held for 2 clk
    wait_ps("rst_sync");
    step(1 + 16'h50 * TICK);
    expect_item(K_OUT, "pre_reset_out", 16'h0101);
    rst_n = 1'b0;
    step(1);
    expect_item(K_OUT, "mid_reset_out", 16'h0000);
    expect_item(K_PS,  "mid_reset_ps", 0);
    step(1);
    rst_n = 1'b1;
    n    = 1;
    seen = 1'b0;
    for (int i = 0; i < PS_BOUND && !seen; i++) begin
      step(1);
      n++;
      seen = period_start;
    end
    if (seen) expect_val("post_reset_period_len", n, PERIOD);
    else      expect_item(K_TIMEOUT, "post_reset_ps", 0);
    wait_ps("post_reset_next");
    expect_item(K_GAP, "post_reset_period", PERIOD);
    expect_item(K_HI,  "post_reset_high", 2496);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
